pool2d_window_sched: RTL and testbench
======================================

POOL2D_WINDOW_SCHED -- requirements
Module: pool2d_window_sched

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, pixel width in bits.
REQ-002 SHALL have parameter DATA_IN_0_WIDTH, default 8, input frame width in pixels.
REQ-003 SHALL have parameter DATA_IN_0_HEIGHT, default 8, input frame height in pixels.
REQ-004 SHALL have parameter KERNEL_WIDTH, default 2, pooling window width.
REQ-005 SHALL have parameter KERNEL_HEIGHT, default 2, pooling window height.
REQ-006 SHALL have parameter STRIDE, default 2, window step in both dimensions.
REQ-007 SHALL derive localparams OUT_W = (DATA_IN_0_WIDTH-KERNEL_WIDTH)/STRIDE+1, OUT_H likewise, and KSIZE = KERNEL_WIDTH*KERNEL_HEIGHT.
REQ-008 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port data_in_0, input, DATA_IN_0_PRECISION_0, one pixel per beat, raster order.
REQ-011 SHALL have port data_in_0_valid, input, 1, and data_in_0_ready, output, 1, input handshake.
REQ-012 SHALL have port data_out_0, output, unpacked array [KSIZE-1:0] of DATA_IN_0_PRECISION_0, window element m*KERNEL_WIDTH+n = pixel at (row*STRIDE+m, col*STRIDE+n).
REQ-013 SHALL have port data_out_0_valid, output, 1, and data_out_0_ready, input, 1, output handshake toward the pooling datapath.
REQ-014 SHALL have port data_out_0_last, output, 1, high with the final window of a frame.

Function
REQ-015 SHALL implement FSM with states LOAD and EMIT; a transfer occurs when valid and ready are both high.
REQ-016 In LOAD, SHALL drive data_in_0_ready=1 and data_out_0_valid=0; each input transfer writes buffer[wr_cnt] and increments wr_cnt.
REQ-017 On the transfer with wr_cnt = WIDTH*HEIGHT-1, SHALL clear wr_cnt and enter EMIT next cycle; first window valid exactly 1 cycle after last pixel accepted.
REQ-018 In EMIT, SHALL drive data_in_0_ready=0 and data_out_0_valid=1; window addressed by counters out_row, out_col, read combinationally from buffer.
REQ-019 On each output transfer, SHALL increment out_col; at OUT_W-1 wrap to 0 and increment out_row.
REQ-020 SHALL assert data_out_0_last iff out_row=OUT_H-1 and out_col=OUT_W-1 in EMIT.
REQ-021 On transfer with data_out_0_last=1, SHALL clear counters and return to LOAD; data_in_0_ready high the following cycle.
REQ-022 While data_out_0_valid=1 and data_out_0_ready=0, data_out_0 and data_out_0_last SHALL remain stable.
REQ-023 Input valid gaps in LOAD SHALL stall wr_cnt with no other effect; data_in_0_valid in EMIT SHALL be ignored.
REQ-024 SHALL elaboration-check (DATA_IN_0_WIDTH-KERNEL_WIDTH)%STRIDE==0, same for height, and STRIDE>=1, with $error on failure.
REQ-025 Counter widths SHALL be $clog2 of their range, minimum 1 bit.

Reset
REQ-026 On rst, SHALL go to LOAD, clear wr_cnt, out_row, out_col; data_out_0_valid=0, data_out_0_last=0, data_in_0_ready=1 once rst deasserts.
REQ-027 Reset mid-LOAD or mid-EMIT SHALL discard the partial frame; buffer contents are not reset and are don't-care until rewritten.

Structure
REQ-028 Package pool2d_pkg SHALL hold the state enum (LOAD, EMIT) and a function computing output dimension from size, kernel, stride.
REQ-029 Pixel storage SHALL be one sub-module pool2d_frame_buffer (1 write port, KSIZE combinational read ports, no reset).

Verification
REQ-030 Default params, pixels 0..63 streamed without gaps -> 16 windows; first {0,1,8,9}; second {2,3,10,11}; last {54,55,62,63} with last=1; first valid 1 cycle after pixel 63.
REQ-031 data_out_0_ready low for 3 cycles on window 5 -> window {18,19,26,27} held stable all 3 cycles; no window skipped or repeated.
REQ-032 Random input valid gaps (50%) -> identical window sequence to REQ-030; data_in_0_ready=0 throughout EMIT.
REQ-033 rst asserted after 20 pixels accepted, then full frame 100..163 -> first window {100,101,108,109}; no window from the aborted frame.
REQ-034 WIDTH=HEIGHT=4, KERNEL 3x3, STRIDE=1, pixels 0..15 -> 4 windows; first {0,1,2,4,5,6,8,9,10}; last {5,6,7,9,10,11,13,14,15} with last=1.
REQ-035 Two back-to-back frames, ready tied high -> data_in_0_ready high cycle after final window transfer; second frame windows correct.

Source files
------------

// File: rtl/pool2d_pkg.sv
// pool2d_pkg: shared state encoding and output-size helper for the pooling window scheduler.
package pool2d_pkg;
  typedef enum logic {LOAD, EMIT} state_t;
  function automatic int out_dim(input int size, input int kernel, input int stride);
    return (size - kernel) / stride + 1;
  endfunction
endpackage

// File: rtl/pool2d_frame_buffer.sv
// pool2d_frame_buffer: one-write, multi-read frame store; contents are never reset.
module pool2d_frame_buffer #(
  parameter int W = 8,
  parameter int DEPTH = 64,
  parameter int NRD = 4,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i [NRD-1:0],
  output logic [W-1:0]  rdata_o [NRD-1:0]
);
  logic [W-1:0] mem_q [DEPTH-1:0];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign rdata_o[r] = mem_q[raddr_i[r]];
  end
endmodule

// File: rtl/pool2d_window_sched.sv
// pool2d_window_sched: buffers a whole frame, then emits every pooling window in raster order.
module pool2d_window_sched
  import pool2d_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_WIDTH = 8,
  parameter int DATA_IN_0_HEIGHT = 8,
  parameter int KERNEL_WIDTH = 2,
  parameter int KERNEL_HEIGHT = 2,
  parameter int STRIDE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_WIDTH*KERNEL_HEIGHT-1:0],
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready,
  output logic                             data_out_0_last
);
  localparam int OUT_W = out_dim(DATA_IN_0_WIDTH, KERNEL_WIDTH, STRIDE);
  localparam int OUT_H = out_dim(DATA_IN_0_HEIGHT, KERNEL_HEIGHT, STRIDE);
  localparam int KSIZE = KERNEL_WIDTH * KERNEL_HEIGHT;
  localparam int NPIX = DATA_IN_0_WIDTH * DATA_IN_0_HEIGHT;
  localparam int AW = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1;
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  if (STRIDE < 1) begin : g_stride_err
    $error("pool2d_window_sched: STRIDE must be >= 1");
  end else if ((DATA_IN_0_WIDTH - KERNEL_WIDTH) % STRIDE != 0 ||
               (DATA_IN_0_HEIGHT - KERNEL_HEIGHT) % STRIDE != 0) begin : g_dim_err
    $error("pool2d_window_sched: kernel/stride do not tile the frame");
  end
  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [AW-1:0] raddr [KSIZE-1:0];
  logic          in_fire, out_fire, last_pix, col_wrap;
  assign in_fire  = data_in_0_valid & data_in_0_ready;
  assign out_fire = data_out_0_valid & data_out_0_ready;
  assign last_pix = wr_cnt_q == AW'(NPIX - 1);
  assign col_wrap = out_col_q == CW'(OUT_W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= LOAD;
      wr_cnt_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = in_fire ? (last_pix ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (in_fire && last_pix) state_d = EMIT;
    if (out_fire) begin
      out_col_d = col_wrap ? '0 : out_col_q + 1'b1;
      out_row_d = col_wrap ? (data_out_0_last ? '0 : out_row_q + 1'b1) : out_row_q;
      state_d   = data_out_0_last ? LOAD : state_q;
    end
  end
  always_comb begin
    data_in_0_ready  = state_q == LOAD;
    data_out_0_valid = state_q == EMIT;
    data_out_0_last  = data_out_0_valid && out_row_q == RW'(OUT_H - 1) && col_wrap;
  end
  // element k sits at kernel row k/KW, column k%KW inside the current window
  always_comb
    for (int k = 0; k < KSIZE; k++)
      raddr[k] = AW'((int'(out_row_q) * STRIDE + k / KERNEL_WIDTH) * DATA_IN_0_WIDTH
                     + int'(out_col_q) * STRIDE + k % KERNEL_WIDTH);
  pool2d_frame_buffer #(
    .W(DATA_IN_0_PRECISION_0),
    .DEPTH(NPIX),
    .NRD(KSIZE),
    .AW(AW)
  ) u_buf (
    .clk(clk),
    .we_i(in_fire),
    .waddr_i(wr_cnt_q),
    .wdata_i(data_in_0),
    .raddr_i(raddr),
    .rdata_o(data_out_0)
  );
endmodule

// File: tb/tb_pool2d_window_sched.sv
// tb_pool2d_window_sched: directed checks of the default 2x2/s2 scheduler and a 3x3/s1 variant.
module tb_pool2d_window_sched;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] din = 0, din3 = 0;
  logic       vin = 0, vin3 = 0, oready = 1, oready3 = 1;
  logic       in_ready, dvalid, dlast, in_ready3, dvalid3, dlast3;
  logic [7:0] dout [3:0];
  logic [7:0] dout3 [8:0];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pool2d_window_sched dut (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(in_ready),
    .data_out_0(dout), .data_out_0_valid(dvalid), .data_out_0_ready(oready), .data_out_0_last(dlast)
  );
  pool2d_window_sched #(
    .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .STRIDE(1)
  ) dut3 (
    .clk(clk), .rst(rst), .data_in_0(din3), .data_in_0_valid(vin3), .data_in_0_ready(in_ready3),
    .data_out_0(dout3), .data_out_0_valid(dvalid3), .data_out_0_ready(oready3), .data_out_0_last(dlast3)
  );
  function automatic logic [31:0] win8();
    return {dout[3], dout[2], dout[1], dout[0]};
  endfunction
  function automatic logic [31:0] expw8(input int base, input int w);
    logic [31:0] e;
    for (int k = 0; k < 4; k++)
      e[k*8 +: 8] = 8'(base + ((w / 4) * 2 + k / 2) * 8 + (w % 4) * 2 + k % 2);
    return e;
  endfunction
  function automatic logic [71:0] win3();
    logic [71:0] g;
    for (int k = 0; k < 9; k++) g[k*8 +: 8] = dout3[k];
    return g;
  endfunction
  function automatic logic [71:0] expw3(input int w);
    logic [71:0] e;
    for (int k = 0; k < 9; k++) e[k*8 +: 8] = 8'((w / 2 + k / 3) * 4 + w % 2 + k % 3);
    return e;
  endfunction
  task automatic send8(input int base, input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      while (gaps && $urandom_range(1, 0) == 1) begin
        vin = 0; din = 8'hEE;
        @(posedge clk); #1;
      end
      vin = 1; din = 8'(base + i);
      @(posedge clk); #1;
    end
    vin = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0; #1;
    tests++;
    if (in_ready !== 1 || dvalid !== 0 || dlast !== 0 || in_ready3 !== 1 || dvalid3 !== 0) begin
      fails++;
      $display("FAIL reset: ready=%b valid=%b last=%b ready3=%b valid3=%b, want 1 0 0 1 0",
               in_ready, dvalid, dlast, in_ready3, dvalid3);
    end
  endtask
  task automatic test_basic();
    @(posedge clk); #1;
    send8(0, 64, 0);
    for (int w = 0; w < 16; w++) begin
      tests++;
      if (dvalid !== 1 || in_ready !== 0 || dlast !== (w == 15) || win8() !== expw8(0, w)) begin
        fails++;
        $display("FAIL basic w%0d: valid=%b last=%b win=%h, want 1 %b %h", w, dvalid, dlast, win8(), w == 15, expw8(0, w));
      end
      if (w == 0 || w == 1 || w == 15) begin
        tests++;
        if (win8() !== (w == 0 ? {8'd9, 8'd8, 8'd1, 8'd0} : w == 1 ? {8'd11, 8'd10, 8'd3, 8'd2} : {8'd63, 8'd62, 8'd55, 8'd54})) begin
          fails++;
          $display("FAIL basic_const w%0d: win=%h", w, win8());
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (in_ready !== 1 || dvalid !== 0) begin
      fails++;
      $display("FAIL basic_return: ready=%b valid=%b, want 1 0", in_ready, dvalid);
    end
  endtask
  task automatic test_stall();
    send8(0, 64, 0);
    for (int w = 0; w < 16; w++) begin
      if (w == 5) begin
        oready = 0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          tests++;
          if (dvalid !== 1 || dlast !== 0 || win8() !== {8'd27, 8'd26, 8'd19, 8'd18}) begin
            fails++;
            $display("FAIL stall cyc%0d: valid=%b last=%b win=%h, want 1 0 1b1a1312", s, dvalid, dlast, win8());
          end
        end
        oready = 1;
      end
      tests++;
      if (dvalid !== 1 || dlast !== (w == 15) || win8() !== expw8(0, w)) begin
        fails++;
        $display("FAIL stall w%0d: valid=%b last=%b win=%h, want 1 %b %h", w, dvalid, dlast, win8(), w == 15, expw8(0, w));
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_gaps();
    send8(0, 64, 1);
    vin = 1; din = 8'hEE;
    for (int w = 0; w < 16; w++) begin
      tests++;
      if (dvalid !== 1 || in_ready !== 0 || dlast !== (w == 15) || win8() !== expw8(0, w)) begin
        fails++;
        $display("FAIL gaps w%0d: valid=%b ready=%b last=%b win=%h, want 1 0 %b %h", w, dvalid, in_ready, dlast, win8(), w == 15, expw8(0, w));
      end
      @(posedge clk); #1;
    end
    vin = 0;
  endtask
  task automatic test_reset_mid();
    send8(200, 20, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; #1;
    tests++;
    if (in_ready !== 1 || dvalid !== 0) begin
      fails++;
      $display("FAIL reset_mid: ready=%b valid=%b, want 1 0", in_ready, dvalid);
    end
    send8(100, 64, 0);
    tests++;
    if (win8() !== {8'd109, 8'd108, 8'd101, 8'd100}) begin
      fails++;
      $display("FAIL reset_mid first: win=%h, want 6d6c6564", win8());
    end
    for (int w = 0; w < 16; w++) begin
      tests++;
      if (dvalid !== 1 || dlast !== (w == 15) || win8() !== expw8(100, w)) begin
        fails++;
        $display("FAIL reset_mid w%0d: valid=%b last=%b win=%h, want 1 %b %h", w, dvalid, dlast, win8(), w == 15, expw8(100, w));
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_k3();
    for (int i = 0; i < 16; i++) begin
      vin3 = 1; din3 = 8'(i);
      @(posedge clk); #1;
    end
    vin3 = 0;
    for (int w = 0; w < 4; w++) begin
      tests++;
      if (dvalid3 !== 1 || in_ready3 !== 0 || dlast3 !== (w == 3) || win3() !== expw3(w)) begin
        fails++;
        $display("FAIL k3 w%0d: valid=%b last=%b win=%h, want 1 %b %h", w, dvalid3, dlast3, win3(), w == 3, expw3(w));
      end
      if (w == 0 || w == 3) begin
        tests++;
        if (win3() !== (w == 0 ? 72'h0a0908060504020100 : 72'h0f0e0d0b0a09070605)) begin
          fails++;
          $display("FAIL k3_const w%0d: win=%h", w, win3());
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (in_ready3 !== 1 || dvalid3 !== 0) begin
      fails++;
      $display("FAIL k3_return: ready=%b valid=%b, want 1 0", in_ready3, dvalid3);
    end
  endtask
  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      send8(f == 0 ? 50 : 7, 64, 0);
      for (int w = 0; w < 16; w++) begin
        tests++;
        if (dvalid !== 1 || dlast !== (w == 15) || win8() !== expw8(f == 0 ? 50 : 7, w)) begin
          fails++;
          $display("FAIL b2b f%0d w%0d: valid=%b last=%b win=%h, want 1 %b %h", f, w, dvalid, dlast, win8(), w == 15, expw8(f == 0 ? 50 : 7, w));
        end
        @(posedge clk); #1;
      end
      tests++;
      if (in_ready !== 1 || dvalid !== 0) begin
        fails++;
        $display("FAIL b2b ready f%0d: ready=%b valid=%b, want 1 0", f, in_ready, dvalid);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_k3();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
